// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, FSM states, ALUop codes and per-state control words for the multi-cycle MIPS controller
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP
    } state_t;

    // Moore control word; ir_write/pc_write in FETCH and done in MEMWR are
    // further qualified by memory-ready in the controller.
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       done;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; c.done = 1'b1; end
            EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_FUNCT; end
            ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            BEQ:     begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALUOP_SUB;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
                c.done      = 1'b1;
            end
            ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDIWB:  begin c.reg_write = 1'b1; c.done = 1'b1; end
            JUMP:    begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.done = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ALU_decoder.sv
// ALU_decoder: maps ALUop and funct to the 3-bit ALU function shared with the single-cycle core
module ALU_decoder (
    input  logic [1:0] ALUop,
    input  logic [5:0] funct,
    output logic [2:0] ALU_control
);

    // add for address/PC arithmetic, subtract for beq, otherwise decode funct
    always_comb begin
        ALU_control = ALUop[1] ? (funct == 6'b100010 ? 3'b110 :
                                  funct == 6'b100100 ? 3'b000 :
                                  funct == 6'b100101 ? 3'b001 :
                                  funct == 6'b101010 ? 3'b111 : 3'b010) :
                      ALUop[0] ? 3'b110 : 3'b010;
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences the shared multi-cycle MIPS datapath, stalling on memory-ready
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int OPC_W         = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             pc_en,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALU_control,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             instr_done,
    output logic             illegal_op
);

    state_t state, nxt;
    ctrl_t  ctrl;
    logic   ready;

    // memory handshake; forced low in reset so no ready-gated strobe leaks out
    assign ready = (mem_ready | ~USE_MEM_READY) & rst_n;

    // next state from current state, decoded opcode and memory handshake
    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:   nxt = ready ? DECODE : FETCH;
            DECODE:  nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                           opcode == OP_RTYPE ? EXEC   :
                           opcode == OP_BEQ   ? BEQ    :
                           opcode == OP_ADDI  ? ADDIEX :
                           opcode == OP_J     ? JUMP   : FETCH;
            MEMADR:  nxt = opcode == OP_LW ? MEMRD : MEMWR;
            MEMRD:   nxt = ready ? MEMWB : MEMRD;
            MEMWR:   nxt = ready ? FETCH : MEMWR;
            EXEC:    nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // state and its Moore control word registered together so outputs align with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= nxt;
            ctrl  <= state_ctrl(nxt);
        end
    end

    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write & ready;
    assign pc_en      = (ctrl.pc_write & (ready | ~ctrl.ir_write)) | (ctrl.branch & zero);
    assign PCSrc      = ctrl.pc_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegWrite   = ctrl.reg_write;
    assign instr_done = ctrl.done & (ready | ~ctrl.mem_write);
    assign illegal_op = (state == DECODE) & ~is_legal(opcode);

    ALU_decoder u_alu_dec (
        .ALUop       (ctrl.alu_op),
        .funct       (funct),
        .ALU_control (ALU_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed table, corner sequences and random instruction stream vs. a reference model
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic        z;
        logic [16:0] exp;
    } vec_t;

    // {IorD, MemWrite, IRWrite, pc_en, PCSrc, ALUSrcA, ALUSrcB, ALU_control, RegDst, MemtoReg, RegWrite, instr_done, illegal_op}
    localparam logic [16:0] W_FETCH    = 17'b0_0_1_1_00_0_01_010_0_0_0_0_0;
    localparam logic [16:0] W_FWAIT    = 17'b0_0_0_0_00_0_01_010_0_0_0_0_0;
    localparam logic [16:0] W_DEC      = 17'b0_0_0_0_00_0_11_010_0_0_0_0_0;
    localparam logic [16:0] W_DEC_ILL  = 17'b0_0_0_0_00_0_11_010_0_0_0_0_1;
    localparam logic [16:0] W_MEMADR   = 17'b0_0_0_0_00_1_10_010_0_0_0_0_0;
    localparam logic [16:0] W_MEMRD    = 17'b1_0_0_0_00_0_00_010_0_0_0_0_0;
    localparam logic [16:0] W_MEMWB    = 17'b0_0_0_0_00_0_00_010_0_1_1_1_0;
    localparam logic [16:0] W_MEMWR_W  = 17'b1_1_0_0_00_0_00_010_0_0_0_0_0;
    localparam logic [16:0] W_MEMWR_D  = 17'b1_1_0_0_00_0_00_010_0_0_0_1_0;
    localparam logic [16:0] W_EXEC_ADD = 17'b0_0_0_0_00_1_00_010_0_0_0_0_0;
    localparam logic [16:0] W_EXEC_0   = 17'b0_0_0_0_00_1_00_000_0_0_0_0_0;
    localparam logic [16:0] W_ALUWB    = 17'b0_0_0_0_00_0_00_010_1_0_1_1_0;
    localparam logic [16:0] W_BEQ_T    = 17'b0_0_0_1_01_1_00_110_0_0_0_1_0;
    localparam logic [16:0] W_BEQ_F    = 17'b0_0_0_0_01_1_00_110_0_0_0_1_0;
    localparam logic [16:0] W_ADDIEX   = 17'b0_0_0_0_00_1_10_010_0_0_0_0_0;
    localparam logic [16:0] W_ADDIWB   = 17'b0_0_0_0_00_0_00_010_0_0_1_1_0;
    localparam logic [16:0] W_JUMP     = 17'b0_0_0_1_10_0_00_010_0_0_0_1_0;

    logic       clk = 1'b0, rst_n = 1'b0, rst_n2 = 1'b0, zero = 1'b0, mem_ready = 1'b1, mr2 = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       IorD, MemWrite, IRWrite, pc_en, ALUSrcA, RegDst, MemtoReg, RegWrite, instr_done, illegal_op;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALU_control;
    logic       IorD2, MemWrite2, IRWrite2, pc_en2, ALUSrcA2, RegDst2, MemtoReg2, RegWrite2, instr_done2, illegal_op2;
    logic [1:0] PCSrc2, ALUSrcB2;
    logic [2:0] ALU_control2;
    logic [16:0] act, act2;
    int tests = 0, fails = 0;
    vec_t tbl[$];
    vec_t q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .pc_en(pc_en), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_control(ALU_control), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    multicycle_controller #(.USE_MEM_READY(1'b0)) dut_nowait (
        .clk(clk), .rst_n(rst_n2), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mr2),
        .IorD(IorD2), .MemWrite(MemWrite2), .IRWrite(IRWrite2), .pc_en(pc_en2), .PCSrc(PCSrc2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALU_control(ALU_control2), .RegDst(RegDst2),
        .MemtoReg(MemtoReg2), .RegWrite(RegWrite2), .instr_done(instr_done2), .illegal_op(illegal_op2)
    );

    assign act  = {IorD, MemWrite, IRWrite, pc_en, PCSrc, ALUSrcA, ALUSrcB, ALU_control,
                   RegDst, MemtoReg, RegWrite, instr_done, illegal_op};
    assign act2 = {IorD2, MemWrite2, IRWrite2, pc_en2, PCSrc2, ALUSrcA2, ALUSrcB2, ALU_control2,
                   RegDst2, MemtoReg2, RegWrite2, instr_done2, illegal_op2};

    function automatic vec_t v(input logic [5:0] op, fn, input logic mr, z, input logic [16:0] exp);
        vec_t r;
        r.op = op; r.fn = fn; r.mr = mr; r.z = z; r.exp = exp;
        return r;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic check(input string name, input logic [16:0] got, want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
        end
    endtask

    // inputs change at posedge+1, outputs sampled on the following negedge
    task automatic apply(input vec_t x, input string name);
        opcode = x.op; funct = x.fn; mem_ready = x.mr; zero = x.z;
        @(negedge clk);
        check(name, act, x.exp);
        @(posedge clk); #1;
    endtask

    // reference model: expand one instruction into its expected per-cycle trace
    task automatic gen(input logic [5:0] op, fn, input logic z, input int fs, ms);
        for (int i = 0; i < fs; i++) q.push_back(v(op, fn, 1'b0, rb(), W_FWAIT));
        q.push_back(v(op, fn, 1'b1, rb(), W_FETCH));
        if (!legal(op)) begin
            q.push_back(v(op, fn, rb(), rb(), W_DEC_ILL));
            return;
        end
        q.push_back(v(op, fn, rb(), rb(), W_DEC));
        if (op == OP_LW || op == OP_SW) begin
            q.push_back(v(op, fn, rb(), rb(), W_MEMADR));
            for (int i = 0; i < ms; i++) q.push_back(v(op, fn, 1'b0, rb(), op == OP_LW ? W_MEMRD : W_MEMWR_W));
            q.push_back(v(op, fn, 1'b1, rb(), op == OP_LW ? W_MEMRD : W_MEMWR_D));
            if (op == OP_LW) q.push_back(v(op, fn, rb(), rb(), W_MEMWB));
        end else if (op == OP_RTYPE) begin
            q.push_back(v(op, fn, rb(), rb(), W_EXEC_0 | {9'd0, alu_of(fn), 5'd0}));
            q.push_back(v(op, fn, rb(), rb(), W_ALUWB));
        end else if (op == OP_BEQ) begin
            q.push_back(v(op, fn, rb(), z, z ? W_BEQ_T : W_BEQ_F));
        end else if (op == OP_ADDI) begin
            q.push_back(v(op, fn, rb(), rb(), W_ADDIEX));
            q.push_back(v(op, fn, rb(), rb(), W_ADDIWB));
        end else begin
            q.push_back(v(op, fn, rb(), rb(), W_JUMP));
        end
    endtask

    initial begin
        logic [5:0] ops[6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [16:0] nowait[6] = '{W_FETCH, W_DEC, W_MEMADR, W_MEMRD, W_MEMWB, W_FETCH};
        logic [5:0] op;

        tbl.push_back(v(OP_LW, 6'd0, 1'b1, 1'b0, W_FETCH));
        tbl.push_back(v(OP_LW, 6'd0, 1'b0, 1'b1, W_DEC));
        tbl.push_back(v(OP_LW, 6'd0, 1'b1, 1'b0, W_MEMADR));
        tbl.push_back(v(OP_LW, 6'd0, 1'b1, 1'b0, W_MEMRD));
        tbl.push_back(v(OP_LW, 6'd0, 1'b0, 1'b0, W_MEMWB));
        tbl.push_back(v(OP_J, 6'd0, 1'b0, 1'b0, W_FWAIT));
        tbl.push_back(v(OP_J, 6'd0, 1'b0, 1'b1, W_FWAIT));
        tbl.push_back(v(OP_J, 6'd0, 1'b1, 1'b0, W_FETCH));
        tbl.push_back(v(OP_J, 6'd0, 1'b1, 1'b0, W_DEC));
        tbl.push_back(v(OP_J, 6'd0, 1'b0, 1'b0, W_JUMP));
        tbl.push_back(v(OP_RTYPE, 6'b100000, 1'b1, 1'b0, W_FETCH));
        tbl.push_back(v(OP_RTYPE, 6'b100000, 1'b1, 1'b0, W_DEC));
        tbl.push_back(v(OP_RTYPE, 6'b100000, 1'b0, 1'b1, W_EXEC_ADD));
        tbl.push_back(v(OP_RTYPE, 6'b100000, 1'b1, 1'b0, W_ALUWB));
        tbl.push_back(v(OP_BEQ, 6'd0, 1'b1, 1'b0, W_FETCH));
        tbl.push_back(v(OP_BEQ, 6'd0, 1'b1, 1'b0, W_DEC));
        tbl.push_back(v(OP_BEQ, 6'd0, 1'b1, 1'b1, W_BEQ_T));
        tbl.push_back(v(OP_BEQ, 6'd0, 1'b1, 1'b1, W_FETCH));
        tbl.push_back(v(OP_BEQ, 6'd0, 1'b1, 1'b1, W_DEC));
        tbl.push_back(v(OP_BEQ, 6'd0, 1'b1, 1'b0, W_BEQ_F));
        tbl.push_back(v(6'b111111, 6'd0, 1'b1, 1'b0, W_FETCH));
        tbl.push_back(v(6'b111111, 6'd0, 1'b1, 1'b0, W_DEC_ILL));
        tbl.push_back(v(OP_ADDI, 6'd0, 1'b1, 1'b0, W_FETCH));
        tbl.push_back(v(OP_ADDI, 6'd0, 1'b1, 1'b0, W_DEC));
        tbl.push_back(v(OP_ADDI, 6'd0, 1'b1, 1'b0, W_ADDIEX));
        tbl.push_back(v(OP_ADDI, 6'd0, 1'b0, 1'b0, W_ADDIWB));
        tbl.push_back(v(OP_SW, 6'd0, 1'b1, 1'b0, W_FETCH));
        tbl.push_back(v(OP_SW, 6'd0, 1'b1, 1'b0, W_DEC));
        tbl.push_back(v(OP_SW, 6'd0, 1'b1, 1'b0, W_MEMADR));
        tbl.push_back(v(OP_SW, 6'd0, 1'b0, 1'b0, W_MEMWR_W));
        tbl.push_back(v(OP_SW, 6'd0, 1'b0, 1'b0, W_MEMWR_W));
        tbl.push_back(v(OP_SW, 6'd0, 1'b0, 1'b0, W_MEMWR_W));
        tbl.push_back(v(OP_SW, 6'd0, 1'b1, 1'b0, W_MEMWR_D));

        repeat (2) @(posedge clk);
        #1;
        check("reset", act, W_FWAIT);
        check("reset_nowait", act2, W_FWAIT);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("table[%0d]", i));

        apply(v(OP_SW, 6'd0, 1'b1, 1'b0, W_FETCH), "rst_sw_fetch");
        apply(v(OP_SW, 6'd0, 1'b1, 1'b0, W_DEC), "rst_sw_dec");
        apply(v(OP_SW, 6'd0, 1'b1, 1'b0, W_MEMADR), "rst_sw_adr");
        mem_ready = 1'b0;
        @(negedge clk);
        check("rst_sw_memwr", act, W_MEMWR_W);
        #2 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1 check("async_reset", act, W_FWAIT);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(v(6'b111111, 6'd0, 1'b1, 1'b0, W_FETCH), "post_reset_fetch");
        apply(v(6'b111111, 6'd0, 1'b1, 1'b0, W_DEC_ILL), "post_reset_illegal");

        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 6));
            if (k < 6) op = ops[k];
            else do op = 6'($urandom_range(0, 63)); while (legal(op));
            q.delete();
            gen(op, op == OP_RTYPE ? fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63)),
                rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            foreach (q[i]) apply(q[i], $sformatf("rand[%0d] op=%b step %0d", n, op, i));
        end

        opcode = OP_LW; funct = 6'd0; mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_n2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("nowait_lw[%0d]", i), act2, nowait[i]);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
